// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the game control path.
//   game_state_t : top-level game phase, shared with the game state machine
//   hp_state_t   : internal state of the player health controller
//   HP_W         : width of the hit-point bus
//   MAX_HP_DEF   : default starting / maximum hit points
//   hp_sat_add   : hit-point addition saturating at a given maximum
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int HP_W       = 4;
    localparam int MAX_HP_DEF = 10;

    typedef enum logic [1:0] {
        MENU       = 2'd0,
        GAME       = 2'd1,
        END_SCREEN = 2'd2
    } game_state_t;

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } hp_state_t;

    // Sum is formed at 32 bits so a large amount can never wrap the 4-bit HP.
    function automatic logic [HP_W-1:0] hp_sat_add(input logic [HP_W-1:0] hp,
                                                   input int unsigned     amt,
                                                   input int unsigned     max_hp);
        int unsigned sum;
        sum = 32'(hp) + amt;
        if (sum > max_hp) begin
            return HP_W'(max_hp);
        end
        return HP_W'(sum);
    endfunction

endpackage

// File: rtl/player_health_ctrl_if.sv
// ---------------------------------------------------------------------------
// player_health_ctrl_if
// Bundles the game-side inputs and renderer/state-machine outputs of the
// player health controller.
//   game_state     : 0 MENU, 1 GAME, 2/3 END_SCREEN
//   frame_tick     : one-cycle pulse per video frame
//   hit, hit_dmg   : collision strobe and its damage (0 = no damage)
//   heal           : one-cycle heal pickup pulse
//   current_health : registered hit points
//   invuln, blink  : invulnerability flag and sprite flash
//   died           : one-cycle pulse on death
// Modports: master drives the inputs (game logic / bench), slave is the
// controller.
// ---------------------------------------------------------------------------
interface player_health_ctrl_if;
    import game_pkg::*;

    // Signalling: there is no valid/ready pair. hit is level-sampled on every
    // clk edge, frame_tick and heal are single-cycle strobes, and every output
    // is a register updated on the clk edge after the input that caused it.
    logic [1:0]      game_state;
    logic            frame_tick;
    logic            hit;
    logic [HP_W-1:0] hit_dmg;
    logic            heal;
    logic [HP_W-1:0] current_health;
    logic            invuln;
    logic            blink;
    logic            died;

    modport master (
        output game_state, frame_tick, hit, hit_dmg, heal,
        input  current_health, invuln, blink, died
    );

    modport slave (
        input  game_state, frame_tick, hit, hit_dmg, heal,
        output current_health, invuln, blink, died
    );

endinterface

// File: rtl/frame_down_counter.sv
// ---------------------------------------------------------------------------
// frame_down_counter
// Loadable down counter stepped by frame ticks, with a zero flag.
//   clk, rst    : clock, asynchronous active-high reset (to RST_VAL)
//   i_load      : load i_load_val (takes priority over i_tick)
//   i_load_val  : value to load
//   i_tick      : decrement by one; the count stops at zero
//   o_cnt       : current count
//   o_zero      : count is zero
// ---------------------------------------------------------------------------
module frame_down_counter #(
    parameter int             W       = 6,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_tick,
    output logic [W-1:0] o_cnt,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/player_health_ctrl.sv
// ---------------------------------------------------------------------------
// player_health_ctrl
// Owns the player's hit points: applies collision damage and heal pickups,
// runs invulnerability frames after each hit, and forces full health in MENU.
//   clk, rst    : clock, asynchronous active-high reset
//   io_hp       : player_health_ctrl_if.slave (game inputs, HP/flag outputs)
//   o_dbg_state : internal ALIVE/INVULN/DEAD state, for observation
// Parameters: MAX_HP (1..15), IFRAME_FRAMES (>=1), HEAL_AMT, REGEN_FRAMES.
// Optional build: define PLAYER_HP_REGEN_EN to add slow health regeneration
// (1 HP every REGEN_FRAMES frames while alive and below MAX_HP). Without it
// no regen logic exists.
// ---------------------------------------------------------------------------
module player_health_ctrl
    import game_pkg::*;
#(
    parameter int MAX_HP        = MAX_HP_DEF,
    parameter int IFRAME_FRAMES = 60,
    parameter int HEAL_AMT      = 2,
    parameter int REGEN_FRAMES  = 180
) (
    input  logic                  clk,
    input  logic                  rst,
    player_health_ctrl_if.slave   io_hp,
    output hp_state_t             o_dbg_state
);

    localparam int              IF_W     = $clog2(IFRAME_FRAMES + 1);
    localparam logic [IF_W-1:0] IF_LOAD  = IF_W'(IFRAME_FRAMES);
    localparam logic [IF_W-1:0] IF_ONE   = IF_W'(1);
    localparam logic [HP_W-1:0] MAX_HP_V = HP_W'(MAX_HP);

    if ((MAX_HP < 1) || (MAX_HP > ((1 << HP_W) - 1)) || (IFRAME_FRAMES < 1) ||
        (HEAL_AMT < 0) || (REGEN_FRAMES < 1)) begin : g_bad_params
        $error("player_health_ctrl: illegal parameter set");
    end

    hp_state_t       r_state, w_state_nxt;
    logic [HP_W-1:0] r_health, w_health_nxt;
    logic            r_invuln;
    logic            r_died, w_died_nxt;

    logic            w_in_menu, w_in_game, w_hit_ok;
    logic [HP_W:0]   w_dmg_diff;
    logic            w_regen_add;
    int unsigned     w_add;

    logic            w_if_load, w_if_tick, w_if_zero, w_blink_bit;
    logic [IF_W-1:0] w_if_load_val, w_if_cnt;

    assign w_in_menu = (io_hp.game_state == MENU);
    assign w_in_game = (io_hp.game_state == GAME);
    assign w_hit_ok  = w_in_game && (r_state == ALIVE) && io_hp.hit && (io_hp.hit_dmg != '0);

    // One extra bit so an overkill hit shows up as a borrow instead of wrapping.
    assign w_dmg_diff = {1'b0, r_health} - {1'b0, io_hp.hit_dmg};

    // HP gained this cycle while ALIVE: heal pickup plus an optional regen step.
    assign w_add = (io_hp.heal ? 32'(HEAL_AMT) : 32'd0) + 32'(w_regen_add);

    // ---------------- invulnerability frame counter ----------------
    frame_down_counter #(
        .W       (IF_W),
        .RST_VAL ('0)
    ) u_iframe_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_if_load),
        .i_load_val (w_if_load_val),
        .i_tick     (w_if_tick),
        .o_cnt      (w_if_cnt),
        .o_zero     (w_if_zero)
    );

    if (IF_W >= 3) begin : g_blink
        assign w_blink_bit = w_if_cnt[2];
    end else begin : g_no_blink
        assign w_blink_bit = 1'b0;
    end

    // ---------------- optional regeneration ----------------
`ifdef PLAYER_HP_REGEN_EN
    localparam int              RG_W    = $clog2(REGEN_FRAMES + 1);
    localparam logic [RG_W-1:0] RG_LOAD = RG_W'(REGEN_FRAMES);
    localparam logic [RG_W-1:0] RG_ONE  = RG_W'(1);

    logic            w_rg_load, w_rg_tick, w_rg_zero;
    logic [RG_W-1:0] w_rg_cnt;

    // The counter holds the frames still to go; "cleared" means reloaded
    // with REGEN_FRAMES, and a step fires on the tick that would reach zero.
    assign w_rg_tick   = w_in_game && (r_state == ALIVE) && !w_hit_ok &&
                         io_hp.frame_tick && (r_health < MAX_HP_V);
    assign w_regen_add = w_rg_tick && ((w_rg_cnt == RG_ONE) || w_rg_zero);
    assign w_rg_load   = w_in_menu ||
                         (w_in_game && ((r_state != ALIVE) || w_hit_ok)) ||
                         w_regen_add;

    frame_down_counter #(
        .W       (RG_W),
        .RST_VAL (RG_LOAD)
    ) u_regen_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_rg_load),
        .i_load_val (RG_LOAD),
        .i_tick     (w_rg_tick),
        .o_cnt      (w_rg_cnt),
        .o_zero     (w_rg_zero)
    );
`else
    assign w_regen_add = 1'b0;
`endif

    // ---------------- health FSM: next state ----------------
    always_comb begin
        w_state_nxt   = r_state;
        w_health_nxt  = r_health;
        w_died_nxt    = 1'b0;
        w_if_load     = 1'b0;
        w_if_load_val = IF_LOAD;
        w_if_tick     = 1'b0;

        case (io_hp.game_state)
            MENU: begin
                w_state_nxt   = ALIVE;
                w_health_nxt  = MAX_HP_V;
                w_if_load     = 1'b1;
                w_if_load_val = '0;
            end
            GAME: begin
                case (r_state)
                    ALIVE: begin
                        if (w_hit_ok) begin
                            // Damage wins over a same-cycle heal.
                            if (w_dmg_diff[HP_W] || (w_dmg_diff[HP_W-1:0] == '0)) begin
                                w_state_nxt  = DEAD;
                                w_health_nxt = '0;
                                w_died_nxt   = 1'b1;
                            end else begin
                                w_state_nxt  = INVULN;
                                w_health_nxt = w_dmg_diff[HP_W-1:0];
                                w_if_load    = 1'b1;
                            end
                        end else if (w_add != 0) begin
                            w_health_nxt = hp_sat_add(r_health, w_add, MAX_HP);
                        end
                    end
                    INVULN: begin
                        if (io_hp.frame_tick) begin
                            w_if_tick = 1'b1;
                            if (w_if_cnt == IF_ONE) begin
                                w_state_nxt = ALIVE;
                            end
                        end
                        // A zero count here means the window is already spent.
                        if (w_if_zero) begin
                            w_state_nxt = ALIVE;
                        end
                        if (io_hp.heal) begin
                            w_health_nxt = hp_sat_add(r_health, HEAL_AMT, MAX_HP);
                        end
                    end
                    DEAD: begin
                        w_health_nxt = '0;
                    end
                    default: begin
                        w_state_nxt = ALIVE;
                    end
                endcase
            end
            default: begin
                // END_SCREEN (and encoding 3): everything holds.
            end
        endcase
    end

    // ---------------- health FSM: registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ALIVE;
            r_health <= MAX_HP_V;
            r_invuln <= 1'b0;
            r_died   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_health <= w_health_nxt;
            r_invuln <= (w_state_nxt == INVULN);
            r_died   <= w_died_nxt;
        end
    end

    assign io_hp.current_health = r_health;
    assign io_hp.invuln         = r_invuln;
    assign io_hp.blink          = r_invuln & w_blink_bit;
    assign io_hp.died           = r_died;
    assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_player_health_ctrl.sv
// ---------------------------------------------------------------------------
// tb_player_health_ctrl
// Self-checking bench for player_health_ctrl: a table of single-cycle vectors,
// hand-written multi-cycle sequences, and randomized traffic checked against
// a behavioural model of the hit-point rules.
// ---------------------------------------------------------------------------
module tb_player_health_ctrl;
    import game_pkg::*;

    localparam int MAX_HP = 10;
    localparam int IFR    = 60;
    localparam int HEAL   = 2;
    localparam int REGEN  = 180;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    player_health_ctrl_if hp_if();
    hp_state_t            dbg_state;

    player_health_ctrl #(
        .MAX_HP        (MAX_HP),
        .IFRAME_FRAMES (IFR),
        .HEAL_AMT      (HEAL),
        .REGEN_FRAMES  (REGEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .io_hp       (hp_if),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Health, remaining invulnerable frames, frames accumulated toward regen.
    int m_hp      = MAX_HP;
    int m_iframes = 0;
    int m_regen   = 0;
    bit m_dead    = 1'b0;
    bit m_died    = 1'b0;

    function automatic int clamp_max(input int v);
        return (v > MAX_HP) ? MAX_HP : v;
    endfunction

    task automatic model_step(input logic r, input logic [1:0] gs, input logic t,
                              input logic h, input logic [3:0] d, input logic hl);
        int add;
        m_died = 1'b0;
        if (r) begin
            m_hp = MAX_HP; m_iframes = 0; m_regen = 0; m_dead = 1'b0;
        end else if (gs == 2'd0) begin
            m_hp = MAX_HP; m_iframes = 0; m_regen = 0; m_dead = 1'b0;
        end else if (gs == 2'd1) begin
            if (m_dead) begin
                m_regen = 0;
            end else if (m_iframes > 0) begin
                m_regen = 0;
                if (hl) m_hp = clamp_max(m_hp + HEAL);
                if (t) m_iframes--;
            end else if (h && d != 4'd0) begin
                m_regen = 0;
                m_hp    = m_hp - int'(d);
                if (m_hp <= 0) begin
                    m_hp = 0; m_dead = 1'b1; m_died = 1'b1;
                end else begin
                    m_iframes = IFR;
                end
            end else begin
                add = hl ? HEAL : 0;
`ifdef PLAYER_HP_REGEN_EN
                if (t && m_hp < MAX_HP) begin
                    m_regen++;
                    if (m_regen == REGEN) begin
                        add++;
                        m_regen = 0;
                    end
                end
`endif
                m_hp = clamp_max(m_hp + add);
            end
        end
        // END_SCREEN: nothing changes.
    endtask

    task automatic check_model(input string tag);
        hp_state_t exp_state;
        logic      exp_inv;
        exp_inv   = (m_iframes > 0);
        exp_state = m_dead ? DEAD : (exp_inv ? INVULN : ALIVE);
        check({tag, ".health"}, 32'(hp_if.current_health), m_hp);
        check({tag, ".invuln"}, 32'(hp_if.invuln), 32'(exp_inv));
        check({tag, ".blink"},  32'(hp_if.blink),  32'(exp_inv && (((m_iframes >> 2) & 1) == 1)));
        check({tag, ".died"},   32'(hp_if.died),   32'(m_died));
        check({tag, ".state"},  32'(dbg_state),    32'(exp_state));
    endtask

    // ---------------- driver ----------------
    // Inputs change 1 time unit after a rising edge; outputs are read 1 unit
    // after the edge that consumed them.
    task automatic cycle(input logic r, input logic [1:0] gs, input logic t,
                         input logic h, input logic [3:0] d, input logic hl);
        rst                 = r;
        hp_if.game_state    = gs;
        hp_if.frame_tick    = t;
        hp_if.hit           = h;
        hp_if.hit_dmg       = d;
        hp_if.heal          = hl;
        @(posedge clk);
        #1;
        model_step(r, gs, t, h, d, hl);
    endtask

    task automatic idle_ticks(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 2'd1, 1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r;
        logic [1:0] gs;
        logic       t;
        logic       h;
        logic [3:0] d;
        logic       hl;
        int         e_hp;
        logic       e_inv;
        logic       e_blk;
        logic       e_died;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs[NVEC];

    initial begin
        //          rst   gs    tick  hit   dmg    heal   hp  inv   blink died
        vecs[0]  = '{1'b1, 2'd0, 1'b0, 1'b0, 4'd0,  1'b0, 10, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b0, 1'b1, 4'd5,  1'b0, 10, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  1'b1, 10, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 2'd1, 1'b0, 1'b0, 4'd0,  1'b0, 10, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 1'b1, 4'd0,  1'b0, 10, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 2'd1, 1'b0, 1'b1, 4'd3,  1'b0,  7, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 2'd1, 1'b0, 1'b1, 4'd3,  1'b0,  7, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 1'b0, 4'd0,  1'b1,  9, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 2'd1, 1'b0, 1'b0, 4'd0,  1'b1, 10, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  1'b0, 10, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 1'b1, 4'd8,  1'b0,  2, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  1'b0, 10, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 2'd1, 1'b0, 1'b1, 4'd15, 1'b0,  0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 2'd1, 1'b0, 1'b0, 4'd0,  1'b0,  0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 2'd1, 1'b0, 1'b1, 4'd3,  1'b1,  0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 4'd0,  1'b0, 10, 1'b0, 1'b0, 1'b0};

        rst              = 1'b1;
        hp_if.game_state = 2'd0;
        hp_if.frame_tick = 1'b0;
        hp_if.hit        = 1'b0;
        hp_if.hit_dmg    = 4'd0;
        hp_if.heal       = 1'b0;
        #1;

        // ---- table-driven single-cycle vectors ----
        for (int i = 0; i < NVEC; i++) begin
            cycle(vecs[i].r, vecs[i].gs, vecs[i].t, vecs[i].h, vecs[i].d, vecs[i].hl);
            check($sformatf("vec%0d.health", i), 32'(hp_if.current_health), vecs[i].e_hp);
            check($sformatf("vec%0d.invuln", i), 32'(hp_if.invuln), 32'(vecs[i].e_inv));
            check($sformatf("vec%0d.blink", i),  32'(hp_if.blink),  32'(vecs[i].e_blk));
            check($sformatf("vec%0d.died", i),   32'(hp_if.died),   32'(vecs[i].e_died));
        end

        // ---- invulnerability window: 60 frames, hit on the last one ignored ----
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 4'd3, 1'b0);
        check("iframe.first_hit", 32'(hp_if.current_health), 32'd7);
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 4'd3, 1'b0);
        check("iframe.second_hit", 32'(hp_if.current_health), 32'd7);
        for (int k = 1; k <= IFR; k++) begin
            cycle(1'b0, 2'd1, 1'b1, (k == IFR), 4'd3, 1'b0);
            check($sformatf("iframe.inv%0d", k), 32'(hp_if.invuln), 32'(k < IFR));
            check($sformatf("iframe.blink%0d", k), 32'(hp_if.blink),
                  (k < IFR) ? 32'(((IFR - k) >> 2) & 1) : 32'd0);
        end
        check("iframe.last_tick_hit", 32'(hp_if.current_health), 32'd7);
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 4'd3, 1'b0);
        check("iframe.after_hit", 32'(hp_if.current_health), 32'd4);
        check("iframe.after_inv", 32'(hp_if.invuln), 32'd1);

        // ---- death without wrap, single died pulse, exit via MENU ----
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 4'd8, 1'b0);
        idle_ticks(IFR);
        check("death.pre_hp", 32'(hp_if.current_health), 32'd2);
        check("death.pre_inv", 32'(hp_if.invuln), 32'd0);
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 4'd5, 1'b0);
        check("death.hp", 32'(hp_if.current_health), 32'd0);
        check("death.died", 32'(hp_if.died), 32'd1);
        cycle(1'b0, 2'd1, 1'b1, 1'b1, 4'd3, 1'b1);
        check("death.died_once", 32'(hp_if.died), 32'd0);
        check("death.ignored", 32'(hp_if.current_health), 32'd0);
        check("death.state", 32'(dbg_state), 32'(DEAD));
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        check("death.menu_hp", 32'(hp_if.current_health), 32'd10);
        check("death.menu_state", 32'(dbg_state), 32'(ALIVE));

        // ---- heal saturation; hit + heal together ----
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 4'd1, 1'b0);
        cycle(1'b0, 2'd1, 1'b0, 1'b0, 4'd0, 1'b1);
        check("heal.saturate", 32'(hp_if.current_health), 32'd10);
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 4'd6, 1'b0);
        idle_ticks(IFR);
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 4'd1, 1'b1);
        check("hitheal.hp", 32'(hp_if.current_health), 32'd3);
        check("hitheal.inv", 32'(hp_if.invuln), 32'd1);

        // ---- END_SCREEN freezes everything; async reset acts at once ----
        cycle(1'b0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0);
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 4'd4, 1'b0);
        for (int k = 0; k < 100; k++)
            cycle(1'b0, (k < 90) ? 2'd2 : 2'd3, 1'b1, k[0], 4'd2, ~k[0]);
        check("end.hp", 32'(hp_if.current_health), 32'd6);
        check("end.inv", 32'(hp_if.invuln), 32'd1);
        rst = 1'b1;
        #1;
        check("rst.async_hp", 32'(hp_if.current_health), 32'd10);
        check("rst.async_inv", 32'(hp_if.invuln), 32'd0);
        cycle(1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0);

`ifdef PLAYER_HP_REGEN_EN
        // ---- regeneration: one HP per 180 frames, restarted by a hit ----
        cycle(1'b0, 2'd1, 1'b0, 1'b1, 4'd3, 1'b0);
        idle_ticks(IFR);
        idle_ticks(REGEN - 1);
        check("regen.before", 32'(hp_if.current_health), 32'd7);
        idle_ticks(1);
        check("regen.step", 32'(hp_if.current_health), 32'd8);
        idle_ticks(REGEN - 1);
        cycle(1'b0, 2'd1, 1'b1, 1'b1, 4'd1, 1'b0);
        check("regen.hit", 32'(hp_if.current_health), 32'd7);
        idle_ticks(IFR + 1);
        check("regen.restarted", 32'(hp_if.current_health), 32'd7);
        cycle(1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0);
`endif

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 4000; n++) begin
            logic       r, t, h, hl;
            logic [1:0] gs;
            logic [3:0] d;
            int         sel;
            r   = ($urandom_range(0, 299) == 0);
            sel = int'($urandom_range(0, 99));
            gs  = (sel < 2) ? 2'd0 : (sel < 5) ? 2'd2 : (sel < 6) ? 2'd3 : 2'd1;
            t   = 1'($urandom_range(0, 1));
            h   = ($urandom_range(0, 11) == 0);
            d   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
            hl  = ($urandom_range(0, 7) == 0);
            cycle(r, gs, t, h, d, hl);
            check_model($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/player_health_ctrl.md
Name: player_health_ctrl

Overview:
- Owns the player's hit points and drives `current_health[3:0]` into the game state machine, which moves GAME -> END_SCREEN when health reaches 0.
- Applies damage from the collision detector, applies heal pickups, and runs invulnerability frames after each hit.
- Holds full health while in MENU, so every new game starts at MAX_HP.
- Also drives `invuln`/`blink` to the player sprite renderer.

Parameters:
- MAX_HP, 10: starting and maximum health; legal range 1..15.
- IFRAME_FRAMES, 60: invulnerability length, counted in frame_tick pulses; must be >= 1.
- HEAL_AMT, 2: HP added per heal pulse.
- REGEN_FRAMES, 180: frames between regen steps; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- game_state  in  2  game state: 0 MENU, 1 GAME, 2 END_SCREEN (3 treated as END_SCREEN).
- frame_tick  in  1  one-cycle pulse per video frame.
- hit  in  1  collision strobe; a level is allowed, and it is sampled every clk.
- hit_dmg  in  4  damage for this hit; 0 means the hit is ignored.
- heal  in  1  one-cycle heal pickup pulse.
- current_health  out  4  registered HP.
- invuln  out  1  high while in INVULN.
- blink  out  1  invuln AND iframe_cnt[2]; sprite flash.
- died  out  1  one-cycle pulse on entering DEAD.

Behaviour:
- Reset values:
  - current_health = MAX_HP, state = ALIVE, iframe_cnt = 0.
  - invuln = 0, blink = 0, died = 0.
- Internal FSM states are ALIVE, INVULN and DEAD. All outputs are registered; the effect of any input is visible on the next clk edge.
- MENU, any internal state:
  - Next state = ALIVE, current_health = MAX_HP.
  - Counters are cleared; hit and heal are ignored.
- END_SCREEN: all registers hold; hit, heal and frame_tick are ignored.
- GAME / ALIVE, on hit && hit_dmg != 0:
  - current_health <= max(current_health - hit_dmg, 0). Use a 5-bit intermediate so the subtraction cannot wrap.
  - If the result is 0: go to DEAD and pulse died.
  - Otherwise: go to INVULN with iframe_cnt <= IFRAME_FRAMES.
- GAME / INVULN:
  - hit is ignored.
  - On frame_tick, iframe_cnt decrements. When it decrements from 1 to 0, the next state is ALIVE.
  - A hit in that same cycle is still ignored.
- GAME / DEAD:
  - current_health stays 0; hit and heal are ignored.
  - Exits only via MENU.
- Heal, in ALIVE or INVULN during GAME:
  - current_health <= min(current_health + HEAL_AMT, MAX_HP).
  - Heal does not change the state or iframe_cnt.
- Hit and heal in the same cycle in ALIVE: damage wins and the heal is dropped.
- Entering GAME from MENU: health is already MAX_HP; no extra initialisation cycle is needed.
- rst mid-game: immediate return to the reset values, including a forced ALIVE from DEAD or INVULN.
- Both IFRAME_FRAMES and iframe_cnt use width $clog2(IFRAME_FRAMES+1).

Optional Feature:
- Macro: PLAYER_HP_REGEN_EN.
- Defined:
  - regen_cnt counts frame_tick pulses while in GAME, state ALIVE and current_health < MAX_HP.
  - On reaching REGEN_FRAMES it adds 1 HP (saturating at MAX_HP) and clears itself.
  - regen_cnt is cleared on any accepted hit, in INVULN, in DEAD and in MENU; it holds in END_SCREEN.
  - A heal pulse and a regen step in the same cycle add HEAL_AMT+1, saturated.
- Undefined: no regen logic is synthesised and REGEN_FRAMES is unused.

Decomposition:
- game_pkg:
  - game_state_t enum (MENU = 0, GAME = 1, END_SCREEN = 2), shared with the game state machine.
  - HP_W = 4 and the default MAX_HP.
  - hp_state_t enum (ALIVE, INVULN, DEAD).
- One natural sub-module: frame_down_counter. It is a loadable frame-tick down counter with a zero flag, instantiated for iframe_cnt, and for regen_cnt when regen is enabled.

Test Plan:
- Reset and hold in MENU -> current_health = 10, invuln = 0, died = 0; hit with dmg 5 during MENU -> health stays 10.
- GAME, hit with dmg 3 -> next cycle health 7 and invuln = 1. A second hit with dmg 3 during INVULN -> health stays 7. After 60 frame_ticks -> invuln = 0; the next hit with dmg 3 -> health 4.
- GAME, health 2, hit with dmg 5 -> health 0 (no wrap), died high for exactly 1 cycle. Later hits and heals are ignored. game_state set to MENU -> health 10, state ALIVE.
- Health 9, heal -> 10 (saturated). Health 4, hit with dmg 1 and heal in the same cycle -> health 3, invuln = 1.
- END_SCREEN with health 6 and invuln = 1: send 100 frame_ticks plus hit and heal -> health 6 and invuln = 1 unchanged. Assert rst -> health 10 and invuln = 0 immediately.
- With PLAYER_HP_REGEN_EN: health 7 in ALIVE, 180 frame_ticks -> 8. A hit at tick 179 restarts the count, so there is no regen at tick 180.
